booth_mult_seq: RTL and testbench

- Multi-cycle signed 32x32 multiplier sequencer for the multdiv unit.
- Owns no adder. It drives the operand and carry-in ports of the shared 32-bit carry-select adder (sum and overflow outputs) once per cycle.
- Runs radix-2 Booth recoding over 32 iterations.
- Returns the low 32 bits of the product, plus an exception flag when the product does not fit in 32 bits.

---
 rtl/booth_mult_seq.sv | 148 ++++++++++++++
 tb/tb_booth_mult_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential signed 32x32 radix-2 Booth multiplier that borrows the shared
// multdiv adder through its add_* ports; returns the low product word plus an overflow flag.
module booth_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_ovf,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_rdy,
    output logic             exception
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] h_reg;
    logic [WIDTH-1:0] l_reg;
    logic             q_reg;
    logic [CNT_W-1:0] count;

    logic             last_iter;
    logic             sum_sign;
    logic [WIDTH-1:0] step_h;
    logic [WIDTH-1:0] step_l;
    logic             step_exc;

    assign last_iter = (count == CNT_W'(WIDTH - 1));

    // The adder's sum bit alone can be wrong when the 33-bit true sum overflows,
    // so the shifted-in sign is recovered from the overflow flag.
    assign sum_sign = add_sum[WIDTH-1] ^ add_ovf;
    assign step_h   = {sum_sign, add_sum[WIDTH-1:1]};
    assign step_l   = {add_sum[0], l_reg[WIDTH-1:1]};
    assign step_exc = (step_h != {WIDTH{step_l[WIDTH-1]}});

    assign busy       = (state == RUN);
    assign result_rdy = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cancel) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Booth pair {L[0], q}: 10 subtracts M, 01 adds M, otherwise H passes through
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a = h_reg;
            case ({l_reg[0], q_reg})
                2'b01: begin
                    add_b = m_reg;
                end
                2'b10: begin
                    add_b   = ~m_reg;
                    add_cin = 1'b1;
                end
                default: begin
                    add_b = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_reg     <= '0;
            h_reg     <= '0;
            l_reg     <= '0;
            q_reg     <= 1'b0;
            count     <= '0;
            result    <= '0;
            exception <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= op_a;
                        h_reg <= '0;
                        l_reg <= op_b;
                        q_reg <= 1'b0;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (!cancel) begin
                        h_reg <= step_h;
                        l_reg <= step_l;
                        q_reg <= l_reg[0];
                        count <= count + 1'b1;
                        if (last_iter) begin
                            result    <= step_l;
                            exception <= step_exc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed plus random test of booth_mult_seq against a plain 64-bit signed
// multiply; the shared carry-select adder is modelled here with ordinary arithmetic.
module tb_booth_mult_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        cancel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_ovf;
    logic        busy;
    logic [31:0] result;
    logic        result_rdy;
    logic        exception;

    int total = 0;
    int bad   = 0;

    logic [32:0] wide_sum;
    logic [31:0] exp_res;
    logic        exp_exc;
    logic [31:0] last_res;
    logic        last_exc;
    int          cyc;
    int          nbusy;
    int          gap;
    int          pulses;

    booth_mult_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .cancel     (cancel),
        .op_a       (op_a),
        .op_b       (op_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_ovf    (add_ovf),
        .busy       (busy),
        .result     (result),
        .result_rdy (result_rdy),
        .exception  (exception)
    );

    always #5 clock = ~clock;

    // Shared adder: signed overflow is carry into the MSB xor carry out of it
    assign wide_sum = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
    assign add_sum  = wide_sum[31:0];
    assign add_ovf  = wide_sum[32] ^ (add_a[31] ^ add_b[31] ^ wide_sum[31]);

    function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic e);
        longint p;
        longint lo_ext;
        p      = longint'($signed(a)) * longint'($signed(b));
        r      = p[31:0];
        lo_ext = longint'($signed(r));
        e      = (p != lo_ext);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // Presents operands with start for one edge; returns #1 after the accepting edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (!result_rdy && cycles < 100) begin
            if (busy) busy_cycles++;
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    task automatic runAndCheck(input logic [31:0] a, input logic [31:0] b, input string tag);
        int c;
        int nb;
        refModel(a, b, exp_res, exp_exc);
        applyStimulus(a, b);
        waitDone(c, nb);
        checkOutput({tag, "_latency"}, 32'(c), 32'd32);
        checkOutput({tag, "_result"}, result, exp_res);
        checkOutput({tag, "_exc"}, {31'b0, exception}, {31'b0, exp_exc});
        @(posedge clock);
        #1;
        checkOutput({tag, "_pulse_end"}, {31'b0, result_rdy}, 32'd0);
        checkOutput({tag, "_hold"}, result, exp_res);
        last_res = exp_res;
        last_exc = exp_exc;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        cancel  = 1'b0;
        op_a    = '0;
        op_b    = '0;
        #12;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_rdy", {31'b0, result_rdy}, 32'd0);
        checkOutput("rst_exc", {31'b0, exception}, 32'd0);
        checkOutput("rst_add_b", add_b, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // 3 x 4 with latency and busy length
        applyStimulus(32'd3, 32'd4);
        waitDone(cyc, nbusy);
        checkOutput("m3x4_latency", 32'(cyc), 32'd32);
        checkOutput("m3x4_busy_cycles", 32'(nbusy), 32'd32);
        checkOutput("m3x4_result", result, 32'h0000000C);
        checkOutput("m3x4_exc", {31'b0, exception}, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("m3x4_pulse_end", {31'b0, result_rdy}, 32'd0);

        runAndCheck(32'hFFFFFFF9, 32'd6, "neg7x6");
        checkOutput("neg7x6_const", last_res, 32'hFFFFFFD6);
        runAndCheck(32'h80000000, 32'hFFFFFFFF, "minxneg1");
        checkOutput("minxneg1_exc_const", {31'b0, last_exc}, 32'd1);
        runAndCheck(32'h7FFFFFFF, 32'd2, "maxx2");
        checkOutput("maxx2_const", last_res, 32'hFFFFFFFE);
        runAndCheck(32'h80000000, 32'd1, "minx1");
        checkOutput("minx1_exc_const", {31'b0, last_exc}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            if (i < 5) begin
                ra = $urandom;
                rb = $urandom;
            end else begin
                ra = 32'($signed(16'($urandom_range(0, 65535))));
                rb = 32'($signed(16'($urandom_range(0, 65535))));
            end
            runAndCheck(ra, rb, $sformatf("rand%0d", i));
        end

        // start pulsed again in RUN cycle 10 must be ignored
        refModel(32'h00012345, 32'hFFFF0055, exp_res, exp_exc);
        applyStimulus(32'h00012345, 32'hFFFF0055);
        repeat (10) @(posedge clock);
        #1;
        op_a  = 32'd7;
        op_b  = 32'd9;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        waitDone(cyc, nbusy);
        checkOutput("restart_latency", 32'(cyc), 32'd21);
        checkOutput("restart_result", result, exp_res);
        checkOutput("restart_exc", {31'b0, exception}, {31'b0, exp_exc});
        last_res = exp_res;
        last_exc = exp_exc;
        @(posedge clock);
        #1;

        // cancel in RUN cycle 20
        applyStimulus(32'h0000DEAD, 32'h0000BEEF);
        repeat (19) @(posedge clock);
        #1;
        cancel = 1'b1;
        @(posedge clock);
        #1;
        cancel = 1'b0;
        checkOutput("cancel_busy", {31'b0, busy}, 32'd0);
        checkOutput("cancel_rdy", {31'b0, result_rdy}, 32'd0);
        checkOutput("cancel_result", result, last_res);
        checkOutput("cancel_exc", {31'b0, exception}, {31'b0, last_exc});
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (result_rdy || busy) pulses++;
        end
        checkOutput("cancel_quiet", 32'(pulses), 32'd0);
        runAndCheck(32'd5, 32'd5, "m5x5");
        checkOutput("m5x5_const", last_res, 32'h00000019);

        // asynchronous reset in RUN cycle 15
        applyStimulus(32'h00001357, 32'h00002468);
        repeat (15) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_busy", {31'b0, busy}, 32'd0);
        checkOutput("arst_result", result, 32'd0);
        checkOutput("arst_rdy", {31'b0, result_rdy}, 32'd0);
        checkOutput("arst_exc", {31'b0, exception}, 32'd0);
        checkOutput("arst_add_a", add_a, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        runAndCheck(32'hFFFFFFFF, 32'hFFFFFFFF, "neg1sq");
        checkOutput("neg1sq_const", last_res, 32'h00000001);

        // back-to-back with start held high
        @(negedge clock);
        op_a  = 32'd2;
        op_b  = 32'd3;
        start = 1'b1;
        @(posedge clock);
        #1;
        op_a = 32'h00010000;
        op_b = 32'h00010000;
        waitDone(cyc, nbusy);
        checkOutput("b2b_first_latency", 32'(cyc), 32'd32);
        checkOutput("b2b_first_result", result, 32'h00000006);
        checkOutput("b2b_first_exc", {31'b0, exception}, 32'd0);
        gap = 0;
        @(posedge clock);
        #1;
        while (!result_rdy && gap < 100) begin
            gap++;
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        checkOutput("b2b_gap", 32'(gap), 32'd33);
        checkOutput("b2b_second_result", result, 32'h00000000);
        checkOutput("b2b_second_exc", {31'b0, exception}, 32'd1);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("b2b_idle_after", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
